// File: rtl/tsmp_arb_pkg.sv
// ---- tsmp_arb_pkg : shared encodings and widths for the TSMP frame arbiter (rev 1.0)
`default_nettype none

package tsmp_arb_pkg;

   localparam int WORD_W = 9;
   localparam int HT_BIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_TRANS = 2'b01,
      ST_DISC  = 2'b10,
      ST_GAP   = 2'b11
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tsmp_frame_arbiter_rr_grant_sel.sv
// ---- rr_grant_sel : combinational round-robin search starting just after rr_ptr (rev 1.0)
`default_nettype none

module rr_grant_sel #(
   parameter int PORT_NUM = 2,
   parameter int IDX_W    = 1
) (
   input  logic [PORT_NUM-1:0] req,
   input  logic [IDX_W-1:0]    rr_ptr,
   output logic [PORT_NUM-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                valid
);

   logic [IDX_W-1:0] cand [PORT_NUM];

   // cand[k] is the port visited k+1 steps after the last winner
   for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_cand
      assign cand[gi] = IDX_W'((int'(rr_ptr) + gi + 1) % PORT_NUM);
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
         if (!valid && req[cand[i]]) begin
            valid           = 1'b1;
            grant_idx       = cand[i];
            grant[cand[i]]  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/tsmp_frame_arbiter.sv
// ---- tsmp_frame_arbiter : frame-atomic round-robin merge of N framed byte streams (rev 1.0)
// ---- Build option TSMP_FRAME_ARB_STAT_EN enables the frame / truncation counters.
`default_nettype none

module tsmp_frame_arbiter
   import tsmp_arb_pkg::*;
#(
   parameter int PORT_NUM   = 2,
   parameter int MAX_LEN    = 1522,
   parameter int IFG_CYCLES = 12
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [PORT_NUM-1:0]        iv_pkt_ready,
   input  logic [WORD_W*PORT_NUM-1:0] iv_fifo_rdata,
   output logic [PORT_NUM-1:0]        ov_fifo_rd,
   input  logic                       i_out_stall,
   output logic [WORD_W-1:0]          ov_data,
   output logic                       o_data_wr,
   output logic [15:0]                ov_frame_cnt,
   output logic [15:0]                ov_trunc_cnt
);

   localparam int IDX_W = idx_width(PORT_NUM);
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam int GAP_W = $clog2(IFG_CYCLES + 1);

   arb_state_t          state, state_nxt;
   logic [IDX_W-1:0]    rr_ptr, grant_idx, sel_idx;
   logic [PORT_NUM-1:0] grant_oh, sel_grant;
   logic                sel_valid;
   logic [CNT_W-1:0]    word_cnt, cnt_nxt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                pop, trans_pop, is_tail, trunc_hit;
   logic [WORD_W-1:0]   fifo_word [PORT_NUM];
   logic [WORD_W-1:0]   cur_word;

   for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_unpack
      assign fifo_word[gp] = iv_fifo_rdata[gp*WORD_W +: WORD_W];
   end

   rr_grant_sel #(
      .PORT_NUM (PORT_NUM),
      .IDX_W    (IDX_W)
   ) u_rr_grant_sel (
      .req       (iv_pkt_ready),
      .rr_ptr    (rr_ptr),
      .grant     (sel_grant),
      .grant_idx (sel_idx),
      .valid     (sel_valid)
   );

   assign cur_word  = fifo_word[grant_idx];
   assign cnt_nxt   = word_cnt + CNT_W'(1);
   // the first word of a grant is always the head, whatever its marker says
   assign is_tail   = (word_cnt != '0) && cur_word[HT_BIT];
   assign trunc_hit = !is_tail && (cnt_nxt == CNT_W'(MAX_LEN));
   assign trans_pop = pop && (state == ST_TRANS);
   assign ov_fifo_rd = pop ? grant_oh : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         ST_IDLE:  if (sel_valid) state_nxt = ST_TRANS;
         ST_TRANS: begin
            if (!i_out_stall) begin
               pop = 1'b1;
               if (is_tail)        state_nxt = ST_GAP;
               else if (trunc_hit) state_nxt = ST_DISC;
            end
         end
         // drain the rest of an oversize frame regardless of downstream stall
         ST_DISC: begin
            pop = 1'b1;
            if (cur_word[HT_BIT]) state_nxt = ST_GAP;
         end
         ST_GAP:   if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr    <= IDX_W'(PORT_NUM - 1);
         grant_idx <= '0;
         grant_oh  <= '0;
         word_cnt  <= '0;
         gap_cnt   <= '0;
         ov_data   <= '0;
         o_data_wr <= 1'b0;
      end else begin
         o_data_wr <= trans_pop;
         gap_cnt   <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
         if (state == ST_IDLE && sel_valid) begin
            rr_ptr    <= sel_idx;
            grant_idx <= sel_idx;
            grant_oh  <= sel_grant;
            word_cnt  <= '0;
         end
         if (trans_pop) begin
            word_cnt <= cnt_nxt;
            ov_data  <= {cur_word[HT_BIT] | trunc_hit, cur_word[HT_BIT-1:0]};
         end
      end
   end

`ifdef TSMP_FRAME_ARB_STAT_EN
   logic [15:0] frame_cnt, trunc_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frame_cnt <= '0;
         trunc_cnt <= '0;
      end else if (trans_pop) begin
         if (is_tail || trunc_hit) frame_cnt <= frame_cnt + 16'd1;
         if (trunc_hit)            trunc_cnt <= trunc_cnt + 16'd1;
      end
   end

   assign ov_frame_cnt = frame_cnt;
   assign ov_trunc_cnt = trunc_cnt;
`else
   assign ov_frame_cnt = '0;
   assign ov_trunc_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/tsmp_frame_arbiter.md
Name: tsmp_frame_arbiter

Overview:
- Frame-atomic round-robin arbiter that merges N framed byte streams into one 9-bit framed stream (bit8 = head/tail marker, bits7:0 = byte) in the TSMP agent.
- Each requester is a show-ahead packet FIFO fed by a head/tail-marking stage.
- Sequences FIFO reads, enforces an inter-frame gap and a maximum frame length, and honours downstream stall.

Parameters:
- PORT_NUM, 2, number of requesters (2..8).
- MAX_LEN, 1522, maximum words per frame before truncation.
- IFG_CYCLES, 12, idle cycles inserted after each frame on the output.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- iv_pkt_ready  input  PORT_NUM  bit p = port p FIFO holds at least one complete frame
- iv_fifo_rdata  input  9*PORT_NUM  show-ahead FIFO heads; port p = bits [9p+8:9p]
- ov_fifo_rd  output  PORT_NUM  one-hot pop strobe to the granted FIFO
- i_out_stall  input  1  downstream stall; no pop while high
- ov_data  output  9  merged framed word
- o_data_wr  output  1  ov_data valid
- ov_frame_cnt  output  16  frames forwarded (macro-dependent)
- ov_trunc_cnt  output  16  frames truncated (macro-dependent)

Behaviour:
- Interface: reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values:
  - Outputs: ov_fifo_rd=0, ov_data=0, o_data_wr=0, counters=0.
  - State: state=IDLE, rr pointer=PORT_NUM-1, word count=0.
- States: IDLE, TRANS, DISC, GAP.
- IDLE:
  - If any iv_pkt_ready bit is set, grant the first set bit searching from rr+1 with wrap, and go to TRANS.
  - rr is updated to the granted port. No pop occurs in the IDLE cycle.
- TRANS:
  - Each cycle with i_out_stall=0, pop the granted port. The next cycle, ov_data equals the popped word and o_data_wr=1, so latency is 1 cycle from pop to output.
  - While i_out_stall=1: no pop, and o_data_wr=0 the next cycle.
- Head and tail decoding:
  - The first word popped in a grant is the head, whatever bit8 holds.
  - The first later word with bit8=1 is the tail. Popping it moves the FSM to GAP.
  - Frames must be at least 2 words; 1-word frames are unsupported and undefined.
- Word counter:
  - Counts pops within a grant and clears on grant.
  - If the popped word is number MAX_LEN and is not the tail, output it with bit8 forced to 1, increment the truncate count, and go to DISC.
- DISC:
  - Pop every cycle, ignoring stall, with o_data_wr=0.
  - Go to GAP after popping a word with bit8=1.
- GAP:
  - Hold for IFG_CYCLES cycles with no pops and no writes, then go to IDLE.
  - The frame count increments on tail output and on truncation.
- Simultaneous events:
  - A pkt_ready bit rising while another port is granted has no effect until IDLE.
  - The granted port's pkt_ready bit is not rechecked during TRANS.
- i_rst_n low mid-frame: everything clears immediately. Partially read frames are the upstream's problem.
- Counters: 16-bit, wrap at 0xFFFF to 0.

Optional Feature:
- Macro: TSMP_FRAME_ARB_STAT_EN.
- Defined: ov_frame_cnt and ov_trunc_cnt are live registers as described.
- Undefined: both outputs are tied to 0 and no counter flops are built. Truncation behaviour is unchanged.

Decomposition:
- Shared package tsmp_arb_pkg:
  - state encodings: IDLE=2'b00, TRANS=2'b01, DISC=2'b10, GAP=2'b11
  - word width constant 9
  - head/tail bit index 8
- Sub-module rr_grant_sel: combinational round-robin search that takes the request vector and the rr pointer and returns a one-hot grant plus an index.

Test Plan:
- PORT_NUM=2, port0 only ready with a 4-word frame 0x1AA,0x011,0x022,0x1BB:
  - ov_data shows the same 4 words on consecutive cycles, 1 cycle after each pop.
  - Then 12 idle cycles; frame_cnt=1.
- Both ports ready continuously, rr after reset: grants alternate port0, port1, port0, with each frame output contiguous and never interleaved.
- i_out_stall held high for 3 cycles in mid-frame: ov_fifo_rd=0 and o_data_wr=0 for exactly 3 cycles, and no word is lost or duplicated.
- MAX_LEN=8 with a 12-word frame:
  - 8 words output, the 8th with bit8=1.
  - 4 words popped silently.
  - trunc_cnt=1, then GAP.
- i_rst_n pulsed low at word 3 of a frame: all outputs go to 0 asynchronously, state is IDLE after release, and the next frame is arbitrated from port0.
- TSMP_FRAME_ARB_STAT_EN undefined, with three frames forwarded: ov_frame_cnt=0 and ov_trunc_cnt=0 throughout.
